// File: rtl/heart_keeper_2p.sv
// Two-player heart/lives keeper with per-player hit invulnerability.
// Ports: Clk, Reset_n, frame_clk, game_start, hit_p1/2, heal_p1/2 in;
//   remaining_hearts(_en), heart_enable, game_over, winner, invuln_p1/2 out.
module heart_keeper_2p #(
  parameter int MAX_HEARTS    = 5,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       game_start,
  input  logic       hit_p1,
  input  logic       hit_p2,
  input  logic       heal_p1,
  input  logic       heal_p2,
  output logic [5:0] remaining_hearts,
  output logic [5:0] remaining_hearts_en,
  output logic       heart_enable,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       invuln_p1,
  output logic       invuln_p2
);

  localparam int IW = (INVULN_FRAMES < 2) ? 1 :
                      $clog2(INVULN_FRAMES + 1);
  localparam logic [5:0]    MAXH = 6'(MAX_HEARTS);
  localparam logic [IW-1:0] INV  = IW'(INVULN_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0][5:0]        cnt_q, cnt_d;
  logic [1:0][IW-1:0]     iv_q, iv_d;
  logic [1:0]             win_q, win_d;
  logic                   frame_q;
  logic                   tick;
  logic [1:0]             hit, heal;

  assign tick = frame_clk & ~frame_q;
  assign hit  = {hit_p2, hit_p1};
  assign heal = {heal_p2, heal_p1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iv_d    = iv_q;
    win_d   = win_q;
    for (int p = 0; p < 2; p++) begin
      if (tick && iv_q[p] != '0)
        iv_d[p] = iv_q[p] - IW'(1);
    end
    unique case (state_q)
      IDLE, OVER: begin
        if (game_start) begin
          cnt_d   = {MAXH, MAXH};
          iv_d    = '0;
          win_d   = 2'b00;
          state_d = PLAY;
        end
      end
      PLAY: begin
        for (int p = 0; p < 2; p++) begin
          // A landed hit wins over a same-cycle heal;
          // an ignored hit lets the heal through.
          if (hit[p] && iv_q[p] == '0) begin
            if (cnt_q[p] != 6'd0)
              cnt_d[p] = cnt_q[p] - 6'd1;
            iv_d[p] = INV;
          end else if (heal[p] && cnt_q[p] < MAXH) begin
            cnt_d[p] = cnt_q[p] + 6'd1;
          end
        end
        if (cnt_d[0] == 6'd0 || cnt_d[1] == 6'd0) begin
          state_d = OVER;
          win_d   = {cnt_d[0] == 6'd0, cnt_d[1] == 6'd0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iv_q    <= '0;
      win_q   <= 2'b00;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iv_q    <= iv_d;
      win_q   <= win_d;
      frame_q <= frame_clk;
    end
  end

  assign remaining_hearts    = cnt_q[0];
  assign remaining_hearts_en = cnt_q[1];
  assign heart_enable        = (state_q != IDLE);
  assign game_over           = (state_q == OVER);
  assign winner              = win_q;
  assign invuln_p1           = |iv_q[0];
  assign invuln_p2           = |iv_q[1];

endmodule

// File: tb/tb_heart_keeper_2p.sv
// Self-checking bench for heart_keeper_2p.
// Directed scenarios plus random traffic against an integer model.
module tb_heart_keeper_2p;

  localparam int MAXH = 5;
  localparam int INV  = 60;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       game_start = 1'b0;
  logic       hit_p1 = 1'b0, hit_p2 = 1'b0;
  logic       heal_p1 = 1'b0, heal_p2 = 1'b0;
  logic [5:0] remaining_hearts, remaining_hearts_en;
  logic       heart_enable, game_over;
  logic [1:0] winner;
  logic       invuln_p1, invuln_p2;

  int checks = 0;
  int errors = 0;

  // model: hearts, invuln frames left, winner, phase 0/1/2
  int m_h[2];
  int m_iv[2];
  int m_win;
  int m_ph;
  int m_prev;

  heart_keeper_2p #(.MAX_HEARTS(MAXH), .INVULN_FRAMES(INV)) dut (
    .Clk                 (Clk),
    .Reset_n             (Reset_n),
    .frame_clk           (frame_clk),
    .game_start          (game_start),
    .hit_p1              (hit_p1),
    .hit_p2              (hit_p2),
    .heal_p1             (heal_p1),
    .heal_p2             (heal_p2),
    .remaining_hearts    (remaining_hearts),
    .remaining_hearts_en (remaining_hearts_en),
    .heart_enable        (heart_enable),
    .game_over           (game_over),
    .winner              (winner),
    .invuln_p1           (invuln_p1),
    .invuln_p2           (invuln_p2)
  );

  always #5 Clk = ~Clk;

  logic [17:0] dvec;
  assign dvec = {remaining_hearts, remaining_hearts_en,
                 heart_enable, game_over, winner,
                 invuln_p1, invuln_p2};

  function automatic logic [17:0] mvec();
    return {6'(m_h[0]), 6'(m_h[1]),
            m_ph != 0, m_ph == 2, 2'(m_win),
            m_iv[0] != 0, m_iv[1] != 0};
  endfunction

  // Advance the model with current inputs, then clock the DUT.
  task automatic step();
    int  oiv[2];
    bit  hit[2];
    bit  heal[2];
    bit  tck;
    hit[0] = hit_p1;   hit[1] = hit_p2;
    heal[0] = heal_p1; heal[1] = heal_p2;
    tck = frame_clk && (m_prev == 0);
    if (!Reset_n) begin
      m_h = '{0, 0}; m_iv = '{0, 0};
      m_win = 0; m_ph = 0; m_prev = 0;
    end else begin
      m_prev = frame_clk;
      oiv = m_iv;
      for (int p = 0; p < 2; p++)
        if (tck && m_iv[p] > 0) m_iv[p]--;
      if (m_ph != 1 && game_start) begin
        m_h = '{MAXH, MAXH}; m_iv = '{0, 0};
        m_win = 0; m_ph = 1;
      end else if (m_ph == 1) begin
        for (int p = 0; p < 2; p++) begin
          if (hit[p] && oiv[p] == 0) begin
            m_h[p] = (m_h[p] > 0) ? m_h[p] - 1 : 0;
            m_iv[p] = INV;
          end else if (heal[p]) begin
            m_h[p] = (m_h[p] < MAXH) ? m_h[p] + 1 : MAXH;
          end
        end
        if (m_h[0] == 0 || m_h[1] == 0) begin
          m_ph = 2;
          m_win = (m_h[0] == 0 ? 2 : 0) + (m_h[1] == 0 ? 1 : 0);
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inv();
    for (int i = 0; i < INV; i++) begin
      frame_clk = 1'b1; step();
      frame_clk = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; step(); step();
    checks++;
    if (dvec !== 18'd0) begin
      errors++;
      $display("FAIL reset outs got %h want 0", dvec);
    end
    Reset_n = 1'b1; step();
    checks++;
    if (heart_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_en got %b want 0", heart_enable);
    end
  endtask

  task automatic test_start();
    game_start = 1'b1; step(); game_start = 1'b0;
    checks++;
    if (remaining_hearts !== 6'd5 ||
        remaining_hearts_en !== 6'd5) begin
      errors++;
      $display("FAIL start_cnt got %0d/%0d want 5/5",
               remaining_hearts, remaining_hearts_en);
    end
    checks++;
    if (heart_enable !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL start_flags en/go got %b%b want 10",
               heart_enable, game_over);
    end
  endtask

  task automatic test_held_hit();
    hit_p1 = 1'b1;
    repeat (100) step();
    checks++;
    if (remaining_hearts !== 6'd4 || invuln_p1 !== 1'b1) begin
      errors++;
      $display("FAIL held_hit got %0d inv %b want 4 inv 1",
               remaining_hearts, invuln_p1);
    end
    for (int i = 0; i < INV; i++) begin
      frame_clk = 1'b1; step();
      if (i == INV - 1) begin
        checks++;
        if (invuln_p1 !== 1'b0 || remaining_hearts !== 6'd4) begin
          errors++;
          $display("FAIL inv_expire got inv %b cnt %0d want 0/4",
                   invuln_p1, remaining_hearts);
        end
      end
      frame_clk = 1'b0; step();
    end
    checks++;
    if (remaining_hearts !== 6'd3 || invuln_p1 !== 1'b1) begin
      errors++;
      $display("FAIL rehit got %0d inv %b want 3 inv 1",
               remaining_hearts, invuln_p1);
    end
    hit_p1 = 1'b0;
    // a long frame_clk level is one tick only
    frame_clk = 1'b1;
    repeat (10) step();
    frame_clk = 1'b0; step();
    for (int k = 1; k <= INV - 1; k++) begin
      frame_clk = 1'b1; step();
      checks++;
      if (invuln_p1 !== (k < INV - 1)) begin
        errors++;
        $display("FAIL level_tick k=%0d got %b want %b",
                 k, invuln_p1, k < INV - 1);
      end
      frame_clk = 1'b0; step();
    end
  endtask

  task automatic test_heal();
    heal_p2 = 1'b1; step(); heal_p2 = 1'b0;
    checks++;
    if (remaining_hearts_en !== 6'd5) begin
      errors++;
      $display("FAIL heal_sat got %0d want 5", remaining_hearts_en);
    end
    hit_p2 = 1'b1; heal_p2 = 1'b1; step();
    hit_p2 = 1'b0; heal_p2 = 1'b0;
    checks++;
    if (remaining_hearts_en !== 6'd4 || invuln_p2 !== 1'b1) begin
      errors++;
      $display("FAIL hit_heal got %0d inv %b want 4 inv 1",
               remaining_hearts_en, invuln_p2);
    end
    heal_p1 = 1'b1; step(); heal_p1 = 1'b0;
    checks++;
    if (remaining_hearts !== 6'd4) begin
      errors++;
      $display("FAIL heal_p1 got %0d want 4", remaining_hearts);
    end
    game_start = 1'b1; step(); game_start = 1'b0;
    checks++;
    if (remaining_hearts !== 6'd4 ||
        remaining_hearts_en !== 6'd4) begin
      errors++;
      $display("FAIL start_in_play got %0d/%0d want 4/4",
               remaining_hearts, remaining_hearts_en);
    end
  endtask

  task automatic test_reset_midround();
    checks++;
    if (invuln_p2 !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_inv got %b want 1", invuln_p2);
    end
    Reset_n = 1'b0; hit_p1 = 1'b1; game_start = 1'b1;
    step();
    Reset_n = 1'b1; hit_p1 = 1'b0; game_start = 1'b0;
    checks++;
    if (dvec !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0", dvec);
    end
    game_start = 1'b1; step(); game_start = 1'b0;
    checks++;
    if (remaining_hearts !== 6'd5 ||
        remaining_hearts_en !== 6'd5) begin
      errors++;
      $display("FAIL restart got %0d/%0d want 5/5",
               remaining_hearts, remaining_hearts_en);
    end
  endtask

  task automatic test_draw();
    for (int r = 0; r < MAXH - 1; r++) begin
      hit_p1 = 1'b1; hit_p2 = 1'b1; step();
      hit_p1 = 1'b0; hit_p2 = 1'b0;
      clear_inv();
    end
    checks++;
    if (remaining_hearts !== 6'd1 ||
        remaining_hearts_en !== 6'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL pre_draw got %0d/%0d go %b want 1/1 go 0",
               remaining_hearts, remaining_hearts_en, game_over);
    end
    hit_p1 = 1'b1; hit_p2 = 1'b1; step();
    checks++;
    if (dvec !== {6'd0, 6'd0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL draw got %h want %h", dvec,
               {6'd0, 6'd0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1});
    end
    clear_inv();
    heal_p1 = 1'b1; heal_p2 = 1'b1;
    repeat (5) step();
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    heal_p1 = 1'b0; heal_p2 = 1'b0;
    checks++;
    if (remaining_hearts !== 6'd0 || remaining_hearts_en !== 6'd0 ||
        winner !== 2'b11 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen got %0d/%0d w %b go %b",
               remaining_hearts, remaining_hearts_en,
               winner, game_over);
    end
    game_start = 1'b1; step(); game_start = 1'b0;
    checks++;
    if (dvec !== {6'd5, 6'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL over_restart got %h want %h", dvec,
               {6'd5, 6'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      Reset_n    = ($urandom_range(0, 1499) != 0);
      game_start = ($urandom_range(0, 79) == 0);
      hit_p1     = ($urandom_range(0, 9) < 2);
      hit_p2     = ($urandom_range(0, 9) < 2);
      heal_p1    = ($urandom_range(0, 29) == 0);
      heal_p2    = ($urandom_range(0, 29) == 0);
      frame_clk  = $urandom_range(0, 1) == 1;
      step();
      checks++;
      if (dvec !== mvec()) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h",
                 i, dvec, mvec());
      end
    end
    Reset_n = 1'b1; game_start = 1'b0;
    hit_p1 = 1'b0; hit_p2 = 1'b0;
    heal_p1 = 1'b0; heal_p2 = 1'b0;
    frame_clk = 1'b0;
  endtask

  initial begin
    m_h = '{0, 0}; m_iv = '{0, 0};
    m_win = 0; m_ph = 0; m_prev = 0;
    test_reset();
    test_start();
    test_held_hit();
    test_heal();
    test_reset_midround();
    test_draw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
